ram2e_slot_sched: RTL and testbench
===================================

Name: ram2e_slot_sched

Overview:
- Central time-slot scheduler for the RAM2E SDRAM.
- Tracks the 16-state IIe cycle counter, locked to the PHI1 rising edge on C14M.
- Drives a single command code per C14M cycle, which the SDRAM pin driver decodes into nCS/nRAS/nCAS/nRWE, plus CKE.
- Shares the one SDRAM between three requesters: the video read slot, the CPU (80-column/RAMWorks) read/write slot and a credit-based refresh scheduler.
- Also owns the power-up init window.

Parameters:
- INIT_CYCLES, 65536: C14M cycles spent in init (S=0) after reset before Ready is set.
- REF_PERIOD, 112: C14M cycles per refresh credit (8 Apple cycles).
- REF_MAX, 7: saturation value of the refresh credit counter; 3-bit counter.

Ports:
- C14M  in  1  14.318 MHz clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- PHI1  in  1  Apple PHI1 (already synchronous to C14M).
- nEN80  in  1  active-low 80-column enable; sampled in S7.
- nWE80  in  1  active-low write strobe; sampled in S8 to select read or write.
- Ready  out  1  init complete.
- S  out  4  IIe state counter.
- Cmd  out  3  command code: 0=NOP, 1=ACT_VID, 2=RD_VID, 3=ACT_CPU, 4=RD_CPU, 5=WR_CPU, 6=REF.
- CKE  out  1  SDRAM clock enable.
- RowLatch  out  1  strobe: latch Ain as row address.
- ColLatch  out  1  strobe: latch Ain as column address.
- VidCap  out  1  strobe: capture video data this cycle.
- CpuCap  out  1  strobe: capture CPU read data this cycle.
- RefOwed  out  3  outstanding refresh credits.
- RefMiss  out  1  sticky: a credit was lost at saturation.

Behaviour:
- Reset, all synchronous:
  - Ready=0, S=0, Cmd=NOP, CKE=0, all strobes 0, RefOwed=0, RefMiss=0.
  - Init counter and refresh timer cleared; PHI1 history register cleared to 0.
  - Reset asserted mid-cycle aborts immediately: the next cycle is NOP with CKE=0, and the full init is rerun.
- Init:
  - Init counter runs 0..INIT_CYCLES-1 with S=0 and Cmd=NOP.
  - CKE=1 during the last 256 init cycles.
  - Ready goes to 1 on the cycle after the counter reaches INIT_CYCLES-1 and stays 1 until Reset.
- S counter:
  - If Ready and PHI1 is 1 now but was 0 last cycle, then S<=1.
  - Otherwise S=0 holds at 0, S=15 holds at 15, and any other value increments.
  - A missing PHI1 edge therefore parks S at 15.
- Slot map (outputs registered, valid in the cycle S shows):
  - S1: NOP.
  - S2: ACT_VID.
  - S3: RD_VID, ColLatch=1.
  - S4, S5: NOP.
  - S6: REF if RefOwed>0, else NOP; VidCap=1.
  - S7: NOP, RowLatch=1; nEN80 sampled.
  - S8: ACT_CPU if the S7 sample was 0, else NOP.
  - S9: if S8 was ACT_CPU, then WR_CPU when the S8 nWE80 sample was 0, else RD_CPU; ColLatch=1 in all cases.
  - S10, S11: NOP.
  - S12: NOP; CpuCap=1 only if S9 was RD_CPU.
  - S13: NOP.
  - S14, S15: NOP, RowLatch=1.
- CKE: 1 in S1-S10, 0 in S11-S15 (and at S=0 after init except the final 256 cycles).
- Refresh credits:
  - After Ready, the timer counts 0..REF_PERIOD-1 and wraps; each wrap is an increment event.
  - Issuing REF is a decrement event.
  - Increment and decrement in the same cycle leave RefOwed unchanged.
  - An increment at REF_MAX keeps RefOwed=REF_MAX and sets RefMiss=1 (cleared only by Reset).
  - A decrement never underflows.
  - While S is parked at 15, no REF is issued, but credits still accrue.
- Priority: the video slot is never displaced; REF only in S6 (and the optional slot below); the CPU slot runs only when requested.

Optional Feature:
- Macro: SCHED_OPPREF_EN.
- Defined: in S8, if the S7 nEN80 sample was 1 and RefOwed>0, then Cmd=REF instead of NOP; this also decrements RefOwed. S9 then issues NOP, still with ColLatch=1.
- Undefined: S8 issues only ACT_CPU or NOP; refresh happens in S6 only.

Test Plan:
- Reset, PHI1 toggling every 14 cycles -> Ready=0 and Cmd=NOP for 65536 cycles; CKE=1 only for the last 256; Ready=1 on the next cycle.
- After Ready, PHI1 rising edge -> S=1 next cycle; Cmd sequence NOP, ACT_VID, RD_VID over S1-S3; CKE falls at S11.
- nEN80=0 in S7 and nWE80=0 in S8 -> S8 ACT_CPU, S9 WR_CPU with ColLatch=1, no CpuCap in S12; repeat with nWE80=1 -> RD_CPU, CpuCap=1 at S12.
- Hold PHI1 low for 1000 cycles -> S parks at 15; RefOwed reaches 7; the next credit sets RefMiss=1; after PHI1 resumes, one REF per S6 until RefOwed=0.
- Timer wrap coinciding with S6 REF while RefOwed=3 -> RefOwed stays 3.
- With SCHED_OPPREF_EN defined, nEN80=1 and RefOwed=2 -> REF at S6 and at S8; RefOwed=0 after S8. Assert Reset at S9 -> next cycle Cmd=NOP, CKE=0, S=0, RefOwed=0.

Source files
------------

// File: rtl/ram2e_slot_sched.sv
// ram2e_slot_sched
// ----------------------------------------------------------------------------
// Central time-slot scheduler for the RAM2E SDRAM.
//
// This block does the following:
//  - Tracks the 16-state IIe cycle counter S, which is locked to the PHI1
//    rising edge.
//  - Produces one command code per C14M cycle, together with CKE and the
//    address/data strobes.
//  - Shares the SDRAM between the video read slot, the CPU read/write slot
//    and a credit-based refresh scheduler.
//  - Owns the power-up init window.
//
// Build option:
//   SCHED_OPPREF_EN - when defined, an idle CPU slot (S8 with nEN80 sampled
//                     high in S7) is used for refresh if a credit is owed.
//
// Ports:
//   C14M      in   14.318 MHz clock, all logic on the rising edge
//   Reset     in   synchronous active-high reset
//   PHI1      in   Apple PHI1, already synchronous to C14M
//   nEN80     in   active-low 80-column enable, sampled in S7
//   nWE80     in   active-low write strobe, sampled in S8
//   Ready     out  init complete
//   S         out  IIe state counter
//   Cmd       out  0=NOP 1=ACT_VID 2=RD_VID 3=ACT_CPU 4=RD_CPU 5=WR_CPU 6=REF
//   CKE       out  SDRAM clock enable
//   RowLatch  out  latch Ain as row address
//   ColLatch  out  latch Ain as column address
//   VidCap    out  capture video data this cycle
//   CpuCap    out  capture CPU read data this cycle
//   RefOwed   out  outstanding refresh credits
//   RefMiss   out  sticky, a credit was lost at saturation
// ----------------------------------------------------------------------------
module ram2e_slot_sched #(
    parameter int INIT_CYCLES = 65536,
    parameter int REF_PERIOD  = 112,
    parameter int REF_MAX     = 7
) (
    input  logic       C14M,
    input  logic       Reset,
    input  logic       PHI1,
    input  logic       nEN80,
    input  logic       nWE80,
    output logic       Ready,
    output logic [3:0] S,
    output logic [2:0] Cmd,
    output logic       CKE,
    output logic       RowLatch,
    output logic       ColLatch,
    output logic       VidCap,
    output logic       CpuCap,
    output logic [2:0] RefOwed,
    output logic       RefMiss
);

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_ACT_VID = 3'd1,
        CMD_RD_VID  = 3'd2,
        CMD_ACT_CPU = 3'd3,
        CMD_RD_CPU  = 3'd4,
        CMD_WR_CPU  = 3'd5,
        CMD_REF     = 3'd6
    } cmd_t;

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int REF_W  = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    // First init counter value at which CKE is raised (last 256 cycles).
    localparam logic [INIT_W-1:0] CKE_FROM  =
        INIT_W'((INIT_CYCLES > 256) ? (INIT_CYCLES - 256) : 0);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REF_PERIOD - 1);
    localparam logic [2:0]        REF_SAT   = 3'(REF_MAX);

    // State registers
    logic              r_ready;
    logic [INIT_W-1:0] r_init_cnt;
    logic [3:0]        r_s;
    logic              r_phi1_prev;
    logic [REF_W-1:0]  r_ref_tmr;
    logic [2:0]        r_ref_owed;
    logic              r_ref_miss;
    logic              r_cpu_act;   // S8 issued ACT_CPU
    logic              r_cpu_rd;    // S9 issued RD_CPU

    // Registered outputs
    cmd_t              r_cmd;
    logic              r_cke;
    logic              r_row;
    logic              r_col;
    logic              r_vid;
    logic              r_cpu;

    // Next-state wires
    logic              w_init_done;
    logic              w_ready_next;
    logic [INIT_W-1:0] w_init_next;
    logic              w_phi1_rise;
    logic [3:0]        w_s_next;
    logic              w_ref_inc;
    logic              w_ref_dec;
    logic [REF_W-1:0]  w_tmr_next;
    logic [2:0]        w_owed_next;
    logic              w_miss_next;
    logic              w_have_credit;
    logic              w_cpu_act_next;
    logic              w_cpu_rd_next;
    cmd_t              w_cmd_next;
    logic              w_cke_next;
    logic              w_row_next;
    logic              w_col_next;
    logic              w_vid_next;
    logic              w_cpu_next;

    // Every output is computed from the S value it will appear alongside,
    // so command and strobes are registered together with S.
    always_comb begin
        w_init_done  = !r_ready && (r_init_cnt == INIT_LAST);
        w_ready_next = r_ready || w_init_done;
        w_init_next  = (r_ready || w_init_done) ? r_init_cnt : r_init_cnt + 1'b1;

        // S resynchronises on every PHI1 rising edge; without one it
        // runs up to 15 and parks there.
        w_phi1_rise = r_ready && PHI1 && !r_phi1_prev;
        if (w_phi1_rise) begin
            w_s_next = 4'd1;
        end else if (r_s == 4'd0 || r_s == 4'd15) begin
            w_s_next = r_s;
        end else begin
            w_s_next = r_s + 4'd1;
        end

        w_ref_inc  = r_ready && (r_ref_tmr == REF_LAST);
        if (!r_ready || w_ref_inc) begin
            w_tmr_next = '0;
        end else begin
            w_tmr_next = r_ref_tmr + 1'b1;
        end

        w_have_credit  = (r_ref_owed != 3'd0);
        w_cmd_next     = CMD_NOP;
        w_row_next     = 1'b0;
        w_col_next     = 1'b0;
        w_vid_next     = 1'b0;
        w_cpu_next     = 1'b0;
        w_cpu_act_next = r_cpu_act;
        w_cpu_rd_next  = r_cpu_rd;

        case (w_s_next)
            4'd2: w_cmd_next = CMD_ACT_VID;
            4'd3: begin
                w_cmd_next = CMD_RD_VID;
                w_col_next = 1'b1;
            end
            4'd6: begin
                w_vid_next = 1'b1;
                if (w_have_credit) begin
                    w_cmd_next = CMD_REF;
                end
            end
            4'd7: w_row_next = 1'b1;
            4'd8: begin
                // S can only reach 8 from 7, so nEN80 here is the S7 sample.
                w_cpu_act_next = !nEN80;
                if (!nEN80) begin
                    w_cmd_next = CMD_ACT_CPU;
                end
`ifdef SCHED_OPPREF_EN
                else if (w_have_credit) begin
                    w_cmd_next = CMD_REF;
                end
`endif
            end
            4'd9: begin
                // nWE80 here is the S8 sample.
                w_col_next    = 1'b1;
                w_cpu_rd_next = r_cpu_act && nWE80;
                if (r_cpu_act) begin
                    w_cmd_next = nWE80 ? CMD_RD_CPU : CMD_WR_CPU;
                end
            end
            4'd12: w_cpu_next = r_cpu_rd;
            4'd14, 4'd15: w_row_next = 1'b1;
            default: ;
        endcase

        w_ref_dec = (w_cmd_next == CMD_REF);

        w_owed_next = r_ref_owed;
        w_miss_next = r_ref_miss;
        if (w_ref_inc && !w_ref_dec) begin
            if (r_ref_owed == REF_SAT) begin
                w_miss_next = 1'b1;
            end else begin
                w_owed_next = r_ref_owed + 3'd1;
            end
        end else if (w_ref_dec && !w_ref_inc) begin
            w_owed_next = r_ref_owed - 3'd1;
        end

        if (!w_ready_next) begin
            w_cke_next = (w_init_next >= CKE_FROM);
        end else begin
            w_cke_next = (w_s_next >= 4'd1) && (w_s_next <= 4'd10);
        end
    end

    always_ff @(posedge C14M) begin
        if (Reset) begin
            r_ready     <= 1'b0;
            r_init_cnt  <= '0;
            r_s         <= 4'd0;
            r_phi1_prev <= 1'b0;
            r_ref_tmr   <= '0;
            r_ref_owed  <= 3'd0;
            r_ref_miss  <= 1'b0;
            r_cpu_act   <= 1'b0;
            r_cpu_rd    <= 1'b0;
            r_cmd       <= CMD_NOP;
            r_cke       <= 1'b0;
            r_row       <= 1'b0;
            r_col       <= 1'b0;
            r_vid       <= 1'b0;
            r_cpu       <= 1'b0;
        end else begin
            r_ready     <= w_ready_next;
            r_init_cnt  <= w_init_next;
            r_s         <= w_s_next;
            r_phi1_prev <= PHI1;
            r_ref_tmr   <= w_tmr_next;
            r_ref_owed  <= w_owed_next;
            r_ref_miss  <= w_miss_next;
            r_cpu_act   <= w_cpu_act_next;
            r_cpu_rd    <= w_cpu_rd_next;
            r_cmd       <= w_cmd_next;
            r_cke       <= w_cke_next;
            r_row       <= w_row_next;
            r_col       <= w_col_next;
            r_vid       <= w_vid_next;
            r_cpu       <= w_cpu_next;
        end
    end

    assign Ready    = r_ready;
    assign S        = r_s;
    assign Cmd      = r_cmd;
    assign CKE      = r_cke;
    assign RowLatch = r_row;
    assign ColLatch = r_col;
    assign VidCap   = r_vid;
    assign CpuCap   = r_cpu;
    assign RefOwed  = r_ref_owed;
    assign RefMiss  = r_ref_miss;

endmodule

// File: tb/tb_ram2e_slot_sched.sv
// tb_ram2e_slot_sched
// ----------------------------------------------------------------------------
// Randomised bench for ram2e_slot_sched. A reference model predicts the full
// output bundle for every cycle and queues it; a monitor on the falling edge
// pops each prediction and compares it with the DUT outputs.
// The init length is shortened to keep the run small.
// ----------------------------------------------------------------------------
module tb_ram2e_slot_sched;

    localparam int INIT = 512;
    localparam int RP   = 112;
    localparam int RM   = 7;
`ifdef SCHED_OPPREF_EN
    localparam bit OPP = 1'b1;
`else
    localparam bit OPP = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       phi1  = 1'b0;
    logic       nen   = 1'b1;
    logic       nwe   = 1'b1;
    logic       ready;
    logic [3:0] s;
    logic [2:0] cmd;
    logic       cke, row, col, vid, cpu;
    logic [2:0] owed;
    logic       miss;

    always #5 clk = ~clk;

    ram2e_slot_sched #(
        .INIT_CYCLES (INIT),
        .REF_PERIOD  (RP),
        .REF_MAX     (RM)
    ) dut (
        .C14M     (clk),
        .Reset    (rst),
        .PHI1     (phi1),
        .nEN80    (nen),
        .nWE80    (nwe),
        .Ready    (ready),
        .S        (s),
        .Cmd      (cmd),
        .CKE      (cke),
        .RowLatch (row),
        .ColLatch (col),
        .VidCap   (vid),
        .CpuCap   (cpu),
        .RefOwed  (owed),
        .RefMiss  (miss)
    );

    typedef struct packed {
        logic       ready;
        logic [3:0] s;
        logic [2:0] cmd;
        logic       cke;
        logic       row;
        logic       col;
        logic       vid;
        logic       cpu;
        logic [2:0] owed;
        logic       miss;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: counts of elapsed cycles and credits, kept as
    // plain integers.
    int m_ready, m_init, m_s, m_phi_prev, m_ready_cycles;
    int m_owed, m_miss, m_req, m_rd;

    function automatic string cmd_name(input int c);
        case (c)
            0: return "NOP";
            1: return "ACT_VID";
            2: return "RD_VID";
            3: return "ACT_CPU";
            4: return "RD_CPU";
            5: return "WR_CPU";
            6: return "REF";
            default: return "???";
        endcase
    endfunction

    always @(posedge clk) begin : model
        obs_t e;
        int   ready_n, init_n, s_n, c, inc;
        e = '0;
        if (rst) begin
            m_ready = 0; m_init = 0; m_s = 0; m_phi_prev = 0; m_ready_cycles = 0;
            m_owed = 0; m_miss = 0; m_req = 0; m_rd = 0;
        end else begin
            ready_n = (m_ready != 0 || m_init == INIT - 1) ? 1 : 0;
            init_n  = ready_n ? m_init : m_init + 1;

            if (m_ready != 0 && phi1 && m_phi_prev == 0) s_n = 1;
            else if (m_s == 0 || m_s == 15)              s_n = m_s;
            else                                         s_n = m_s + 1;

            // One credit is earned at the end of every REF_PERIOD-th Ready cycle.
            inc = 0;
            if (m_ready != 0) begin
                m_ready_cycles++;
                inc = (m_ready_cycles % RP == 0) ? 1 : 0;
            end

            c = 0;
            case (s_n)
                2: c = 1;
                3: begin c = 2; e.col = 1'b1; end
                6: begin e.vid = 1'b1; if (m_owed > 0) c = 6; end
                7: e.row = 1'b1;
                8: begin
                    m_req = nen ? 0 : 1;
                    if (!nen) c = 3;
                    else if (OPP && m_owed > 0) c = 6;
                end
                9: begin
                    e.col = 1'b1;
                    if (m_req != 0) c = nwe ? 4 : 5;
                    m_rd = (c == 4) ? 1 : 0;
                end
                12: e.cpu = (m_rd != 0);
                14, 15: e.row = 1'b1;
                default: ;
            endcase

            if (inc != 0 && c != 6) begin
                if (m_owed == RM) m_miss = 1;
                else              m_owed++;
            end else if (inc == 0 && c == 6) begin
                m_owed--;
            end

            if (ready_n == 0) e.cke = (init_n >= INIT - 256);
            else              e.cke = (s_n >= 1 && s_n <= 10);

            if (c >= 4)
                $display("txn t=%0t S=%0d cmd=%s owed=%0d miss=%0d",
                         $time, s_n, cmd_name(c), m_owed, m_miss);

            m_ready    = ready_n;
            m_init     = init_n;
            m_s        = s_n;
            m_phi_prev = phi1 ? 1 : 0;
            e.ready    = (ready_n != 0);
            e.s        = 4'(s_n);
            e.cmd      = 3'(c);
            e.owed     = 3'(m_owed);
            e.miss     = (m_miss != 0);
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        obs_t g, w;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            g = {ready, s, cmd, cke, row, col, vid, cpu, owed, miss};
            checks++;
            if (g !== w) begin
                errors++;
                $display("FAIL outputs t=%0t got rdy=%0d S=%0d cmd=%0d cke=%0d row=%0d col=%0d vid=%0d cpu=%0d owed=%0d miss=%0d want rdy=%0d S=%0d cmd=%0d cke=%0d row=%0d col=%0d vid=%0d cpu=%0d owed=%0d miss=%0d",
                         $time, g.ready, g.s, g.cmd, g.cke, g.row, g.col, g.vid, g.cpu, g.owed, g.miss,
                         w.ready, w.s, w.cmd, w.cke, w.row, w.col, w.vid, w.cpu, w.owed, w.miss);
            end
        end
    end

    // PHI1 generator: 7 cycles high per Apple cycle of 14 (occasionally 16)
    // C14M cycles; "gap" holds PHI1 low.
    int ph  = 0;
    int per = 14;

    task automatic step(input bit gap);
        @(negedge clk);
        if (gap) begin
            phi1 = 1'b0;
        end else begin
            phi1 = (ph < 7);
            ph++;
            if (ph >= per) begin
                ph  = 0;
                per = ($urandom_range(0, 7) == 0) ? 16 : 14;
            end
        end
        nen = 1'($urandom_range(0, 1));
        nwe = 1'($urandom_range(0, 1));
    endtask

    initial begin : driver
        bit found;
        rst = 1'b1;
        repeat (3) step(1'b0);
        rst = 1'b0;
        repeat (INIT + 100) step(1'b0);
        repeat (3000) step(1'b0);

        // Long PHI1 outage: S parks, credits saturate, RefMiss sets.
        repeat (1000) step(1'b1);
        ph = 0;
        repeat (2000) step(1'b0);

        // Random outages shift the refresh timer against the slot phase.
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(200, 600)) step(1'b0);
            repeat ($urandom_range(20, 400)) step(1'b1);
            ph = 0;
        end
        repeat (300) step(1'b0);

        // Reset asserted while S=9 must abort at once and rerun init.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b0);
            if (m_s == 9) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL find_s9 got S=%0d required S=9 within 200 cycles", m_s);
        end
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        repeat (INIT + 1500) step(1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
